// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared helpers for latency-matching pipelines: occupancy
//                count width and stage-count sanity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Width needed to hold an occupancy value in 0..l.
    function automatic int cnt_width(input int l);
        return (l < 1) ? 1 : $clog2(l + 1);
    endfunction

    // A pipe needs at least one register stage.
    function automatic bit stages_ok(input int l);
        return (l >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_stage
//  Description : One valid/data register pair of the elastic delay pipe.
//                Optional macro ELASTIC_DELAY_DATA_RST_EN adds a reset to the
//                data register; otherwise data has no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          en,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Valid bit: cleared by reset or flush, otherwise follows its source when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (en) begin
            r_valid <= src_valid;
        end
    end

`ifdef ELASTIC_DELAY_DATA_RST_EN
    // Data register with reset; loads only real words to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (!flush && en && src_valid) begin
            r_data <= src_data;
        end
    end
`else
    // Data register without reset; loads only real words to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (!rst && !flush && en && src_valid) begin
            r_data <= src_data;
        end
    end
`endif

    assign valid = r_valid;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/elastic_delay.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_delay
//  Description : L-stage delay pipe with per-stage valids, valid/ready on both
//                sides, bubble collapsing, synchronous flush and occupancy
//                count. Macro ELASTIC_DELAY_DATA_RST_EN enables data reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_delay
    import pipe_pkg::*;
#(
    parameter  int DW = 16,
    parameter  int L  = 4,
    localparam int CW = cnt_width(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] count
);

    if (!stages_ok(L)) begin : g_l_check
        $error("elastic_delay: L must be at least 1");
    end

    logic [L:0]    w_en;
    logic [L-1:0]  w_valid;
    logic [DW-1:0] w_data [L];
    logic [L-1:0]  w_src_valid;
    logic [DW-1:0] w_src_data [L];
    logic          w_in_xfer;
    logic          w_out_xfer;
    logic [CW-1:0] r_count;

    // Enable chain: a stage may advance if it is empty or its successor advances.
    always_comb begin
        w_en    = '0;
        w_en[L] = m_ready;
        for (int i = L - 1; i >= 0; i--) begin
            w_en[i] = !w_valid[i] || w_en[i+1];
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_src_valid[i] = s_valid;
            assign w_src_data[i]  = s_data;
        end else begin : g_body
            assign w_src_valid[i] = w_valid[i-1];
            assign w_src_data[i]  = w_data[i-1];
        end

        elastic_stage #(
            .DW (DW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .en        (w_en[i]),
            .src_valid (w_src_valid[i]),
            .src_data  (w_src_data[i]),
            .valid     (w_valid[i]),
            .data      (w_data[i])
        );
    end

    // Reset and flush block both handshakes so no word moves in those cycles.
    assign s_ready    = w_en[0] && !flush && !rst;
    assign m_valid    = w_valid[L-1] && !flush && !rst;
    assign m_data     = w_data[L-1];
    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = m_valid && m_ready;

    // Occupancy: tracks the number of valid stages via transfer events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_elastic_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_delay
//  Description : Directed self-checking bench for elastic_delay (DW=16, L=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_delay;

    localparam int DW = 16;
    localparam int L  = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [2:0]    count;

    int checks;
    int errors;

    elastic_delay #(
        .DW (DW),
        .L  (L)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int outn;
        logic exp_mv;

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // ---------------- reset ----------------
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst_count",   {29'd0, count},   32'd0);
        check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        cyc();

        // ---------------- streaming, latency 4 ----------------
        m_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            s_valid = (c < 8);
            s_data  = 16'(c + 1);
            #1;
            exp_mv = (c >= 4 && c < 12);
            check("t1_m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
            if (exp_mv) check("t1_m_data", {16'd0, m_data}, 32'(c - 3));
            acc  = (c < 8) ? c : 8;
            outn = (c > 4) ? (((c - 4) < 8) ? (c - 4) : 8) : 0;
            check("t1_count",   {29'd0, count},   32'(acc - outn));
            check("t1_s_ready", {31'd0, s_ready}, 32'd1);
            cyc();
        end
        s_valid = 1'b0;

        // ---------------- fill then stall ----------------
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_valid = 1'b1;
            s_data  = 16'(c + 1);
            #1;
            check("t2_fill_s_ready", {31'd0, s_ready}, 32'd1);
            cyc();
        end
        s_data = 16'h0005;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t2_stall_s_ready", {31'd0, s_ready}, 32'd0);
            check("t2_stall_m_valid", {31'd0, m_valid}, 32'd1);
            check("t2_stall_m_data",  {16'd0, m_data},  32'h0001);
            check("t2_stall_count",   {29'd0, count},   32'd4);
            cyc();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t2_drain_m_valid", {31'd0, m_valid}, 32'd1);
            check("t2_drain_m_data",  {16'd0, m_data},  32'(c + 1));
            cyc();
        end
        #1;
        check("t2_empty_m_valid", {31'd0, m_valid}, 32'd0);
        check("t2_empty_count",   {29'd0, count},   32'd0);

        // ---------------- bubble collapse ----------------
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h00A1; cyc();
        s_valid = 1'b0; s_data = 16'hDEAD; cyc();
        s_valid = 1'b1; s_data = 16'h00A2; cyc();
        s_valid = 1'b0; s_data = 16'hBEEF; cyc();
        #1;
        check("t3_count", {29'd0, count}, 32'd2);
        cyc();
        cyc();
        cyc();
        check("t3_m_valid", {31'd0, m_valid}, 32'd1);
        check("t3_m_data",  {16'd0, m_data},  32'h00A1);
        check("t3_s_ready", {31'd0, s_ready}, 32'd1);
        check("t3_count2",  {29'd0, count},   32'd2);
        m_ready = 1'b1;
        cyc();
        check("t3_adj_m_valid", {31'd0, m_valid}, 32'd1);
        check("t3_adj_m_data",  {16'd0, m_data},  32'h00A2);
        cyc();
        check("t3_done_m_valid", {31'd0, m_valid}, 32'd0);
        check("t3_done_count",   {29'd0, count},   32'd0);

        // ---------------- flush ----------------
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h00B1; cyc();
        s_data = 16'h00B2; cyc();
        s_data = 16'h00B3; cyc();
        s_valid = 1'b0;
        cyc();
        check("t4_pre_count",   {29'd0, count},   32'd3);
        check("t4_pre_m_valid", {31'd0, m_valid}, 32'd1);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h00B4;
        m_ready = 1'b1;
        #1;
        check("t4_fl_s_ready", {31'd0, s_ready}, 32'd0);
        check("t4_fl_m_valid", {31'd0, m_valid}, 32'd0);
        cyc();
        flush   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("t4_post_count",   {29'd0, count},   32'd0);
        check("t4_post_m_valid", {31'd0, m_valid}, 32'd0);
        check("t4_post_s_ready", {31'd0, s_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("t4_no_ghost", {31'd0, m_valid}, 32'd0);
        end

        // ---------------- full pipe, simultaneous in/out ----------------
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h00C1 + c);
            cyc();
        end
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h00C5 + c);
            #1;
            check("t5_s_ready", {31'd0, s_ready}, 32'd1);
            check("t5_m_valid", {31'd0, m_valid}, 32'd1);
            check("t5_m_data",  {16'd0, m_data},  32'(32'h00C1 + c));
            check("t5_count",   {29'd0, count},   32'd4);
            cyc();
        end
        s_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t5_drain_m_valid", {31'd0, m_valid}, 32'd1);
            check("t5_drain_m_data",  {16'd0, m_data},  32'(32'h00C5 + c));
            cyc();
        end
        check("t5_empty_count", {29'd0, count}, 32'd0);

        // ---------------- reset mid-operation ----------------
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 16'h00D1; cyc();
        s_data = 16'h00D2; cyc();
        s_valid = 1'b0;
        cyc();
        check("t6_pre_count", {29'd0, count}, 32'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("t6_post_count",   {29'd0, count},   32'd0);
        check("t6_post_m_valid", {31'd0, m_valid}, 32'd0);
        check("t6_post_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef ELASTIC_DELAY_DATA_RST_EN
        check("t6_post_m_data", {16'd0, m_data}, 32'h0000);
`endif
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("t6_discarded", {31'd0, m_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
